// File: rtl/wb_project_decoder.sv
// Wishbone decoder and response mux for the shared user-area project slots.
// Optional status register at 0x3Fxx_xxxx is built when WB_DECODER_STATUS_EN is defined.
module wb_project_decoder #(
  parameter int          NUM_SLOTS = 16,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hBAD0_0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [NUM_SLOTS-1:0]   active,
  output logic                   slot_cyc_o,
  output logic                   slot_we_o,
  output logic [NUM_SLOTS-1:0]   slot_stb_o,
  output logic [3:0]             slot_sel_o,
  output logic [31:0]            slot_adr_o,
  output logic [31:0]            slot_dat_o,
  input  logic [NUM_SLOTS-1:0]   slot_ack_i,
  input  logic [32*NUM_SLOTS-1:0] slot_dat_i,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  slot_q;
  logic [7:0]  cnt;

  logic [3:0]   req_slot;
  logic [15:0]  act_pad;
  logic [15:0]  ack_pad;
  logic [511:0] dat_pad;
  logic [15:0]  req_onehot;
  logic         in_range;
  logic         user_space;
  logic         stat_space;
  logic         hit;
  logic         slot_ack;
  logic         to_fire;
  logic [31:0]  req_err;
  logic [31:0]  cur_err;
  logic [31:0]  slot_rd;

  assign req_slot   = wbs_adr_i[23:20];
  assign act_pad    = 16'(active);
  assign ack_pad    = 16'(slot_ack_i);
  assign dat_pad    = 512'(slot_dat_i);
  assign req_onehot = 16'h1 << req_slot;
  assign in_range   = {1'b0, req_slot} < 5'(NUM_SLOTS);
  assign user_space = wbs_adr_i[31:28] == 4'h3;
  assign stat_space = user_space && (wbs_adr_i[27:24] == 4'hF);
  assign hit        = user_space && !stat_space && in_range
                      && act_pad[req_slot];
  assign req_err    = ERR_DATA | {28'h0, req_slot};
  assign cur_err    = ERR_DATA | {28'h0, slot_q};
  assign slot_rd    = dat_pad[{slot_q, 5'b0} +: 32];
  assign slot_ack   = ack_pad[slot_q];
  // An ack in the final counted cycle still beats the timeout.
  assign to_fire    = (state == BUSY) && wbs_cyc_i && !slot_ack
                      && (cnt == 8'(TIMEOUT));

`ifdef WB_DECODER_STATUS_EN
  logic [7:0]  to_count;
  logic [3:0]  to_slot;
  logic [31:0] stat_word;

  assign stat_word = {8'h0, to_count, to_slot, 11'h0, timeout_o};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_count <= '0;
      to_slot  <= '0;
    end else if (to_fire) begin
      to_slot <= slot_q;
      if (to_count != 8'hFF) to_count <= to_count + 8'd1;
    end
  end
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      slot_q     <= '0;
      cnt        <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      slot_cyc_o <= 1'b0;
      slot_we_o  <= 1'b0;
      slot_stb_o <= '0;
      slot_sel_o <= '0;
      slot_adr_o <= '0;
      slot_dat_o <= '0;
      timeout_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            slot_adr_o <= wbs_adr_i;
            slot_dat_o <= wbs_dat_i;
            slot_sel_o <= wbs_sel_i;
            slot_we_o  <= wbs_we_i;
            slot_q     <= req_slot;
            cnt        <= '0;
            if (hit) begin
              state      <= BUSY;
              slot_cyc_o <= 1'b1;
              slot_stb_o <= req_onehot[NUM_SLOTS-1:0];
`ifdef WB_DECODER_STATUS_EN
            end else if (stat_space) begin
              state     <= RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= wbs_we_i ? 32'h0 : stat_word;
`endif
            end else begin
              state     <= RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= req_err;
            end
          end
        end
        BUSY: begin
          if (!wbs_cyc_i) begin
            state      <= IDLE;
            slot_cyc_o <= 1'b0;
            slot_stb_o <= '0;
          end else if (slot_ack) begin
            state      <= RESP;
            wbs_ack_o  <= 1'b1;
            wbs_dat_o  <= slot_we_o ? 32'h0 : slot_rd;
            slot_cyc_o <= 1'b0;
            slot_stb_o <= '0;
          end else if (to_fire) begin
            state      <= RESP;
            wbs_ack_o  <= 1'b1;
            wbs_dat_o  <= cur_err;
            timeout_o  <= 1'b1;
            slot_cyc_o <= 1'b0;
            slot_stb_o <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_project_decoder.sv
// Scoreboard bench for wb_project_decoder: expected ack data is queued
// on request and checked by a monitor whenever the decoder acks.
module tb_wb_project_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         stb, cyc, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [15:0]  active;
  logic         s_cyc, s_we;
  logic [15:0]  s_stb;
  logic [3:0]   s_sel;
  logic [31:0]  s_adr, s_dat;
  logic [15:0]  s_ack;
  logic [511:0] s_rdat;
  logic         to;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_project_decoder dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .active    (active),
    .slot_cyc_o(s_cyc),
    .slot_we_o (s_we),
    .slot_stb_o(s_stb),
    .slot_sel_o(s_sel),
    .slot_adr_o(s_adr),
    .slot_dat_o(s_dat),
    .slot_ack_i(s_ack),
    .slot_dat_i(s_rdat),
    .timeout_o (to)
  );

  // Scoreboard monitor: every ack must match the oldest queued response.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: got ack data=%h, want no ack", rdat);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdat !== e) begin
          n_err++;
          $display("FAIL ack_data: got %h want %h", rdat, e);
        end
      end
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic w,
                           input logic [31:0] d);
    adr = a; we = w; wdat = d; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic drop_req;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; drop_req(); we = 0; sel = 0; adr = 0; wdat = 0;
    active = 16'h0; s_ack = 16'h0; s_rdat = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack, rdat, s_cyc, s_we, s_stb, s_sel, s_adr, s_dat, to} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b dat=%h stb=%h cyc=%b to=%b, want all 0",
               ack, rdat, s_stb, s_cyc, to);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_mapped;
    active = 16'h0001;
    drive_req(32'h3000_0010, 1'b0, 32'h0);
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    n_cmp++;
    if (s_stb !== 16'h0001 || s_cyc !== 1'b1 || s_adr !== 32'h3000_0010) begin
      n_err++;
      $display("FAIL rd_strobe: got stb=%h cyc=%b adr=%h want 0001/1/30000010",
               s_stb, s_cyc, s_adr);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || s_stb !== 16'h0001) begin
      n_err++;
      $display("FAIL rd_wait: got ack=%b stb=%h want 0/0001", ack, s_stb);
    end
    s_ack = 16'h0001;
    s_rdat[31:0] = 32'h1234_5678;
    @(negedge clk);
    s_ack = 16'h0;
    n_cmp++;
    if (ack !== 1'b1 || s_stb !== 16'h0) begin
      n_err++;
      $display("FAIL rd_ack_timing: got ack=%b stb=%h want 1/0000", ack, s_stb);
    end
    drop_req();
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || rdat !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL rd_hold: got ack=%b dat=%h want 0/12345678", ack, rdat);
    end
  endtask

  task automatic test_inactive;
    active = 16'h0001;
    drive_req(32'h3020_0000, 1'b0, 32'h0);
    exp_q.push_back(32'hBAD0_0002);
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b1 || s_stb !== 16'h0 || s_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL inactive_err: got ack=%b stb=%h cyc=%b want 1/0000/0",
               ack, s_stb, s_cyc);
    end
    drop_req();
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int  c;
    bit  seen;
    active = 16'h0009;
    n_cmp++;
    if (to !== 1'b0) begin
      n_err++;
      $display("FAIL to_pre: got timeout=%b want 0", to);
    end
    drive_req(32'h3030_0004, 1'b1, 32'hA5A5_5A5A);
    exp_q.push_back(32'hBAD0_0003);
    @(negedge clk);
    n_cmp++;
    if (s_stb !== 16'h0008 || s_we !== 1'b1 || s_dat !== 32'hA5A5_5A5A) begin
      n_err++;
      $display("FAIL to_strobe: got stb=%h we=%b dat=%h want 0008/1/a5a55a5a",
               s_stb, s_we, s_dat);
    end
    c = 0; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      c++;
      if (ack === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen || c != 256) begin
      n_err++;
      $display("FAIL to_latency: got seen=%0d cycles=%0d want 1/256", seen, c);
    end
    n_cmp++;
    if (to !== 1'b1) begin
      n_err++;
      $display("FAIL to_flag: got %b want 1", to);
    end
    drop_req();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (to !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky: got %b want 1", to);
    end
  endtask

  task automatic test_status;
    active = 16'h0009;
    drive_req(32'h3F00_0000, 1'b0, 32'h0);
`ifdef WB_DECODER_STATUS_EN
    exp_q.push_back(32'h0001_3001);
`else
    exp_q.push_back(32'hBAD0_0000);
`endif
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b1 || s_stb !== 16'h0) begin
      n_err++;
      $display("FAIL status_timing: got ack=%b stb=%h want 1/0000", ack, s_stb);
    end
    drop_req();
    @(negedge clk);
  endtask

  task automatic test_abort;
    active = 16'h0002;
    drive_req(32'h3010_0000, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    drop_req();
    @(negedge clk);
    n_cmp++;
    if (s_stb !== 16'h0 || s_cyc !== 1'b0 || ack !== 1'b0) begin
      n_err++;
      $display("FAIL abort_clear: got stb=%h cyc=%b ack=%b want 0000/0/0",
               s_stb, s_cyc, ack);
    end
    repeat (2) @(negedge clk);
    drive_req(32'h3010_0008, 1'b0, 32'h0);
    exp_q.push_back(32'hCAFE_0001);
    @(negedge clk);
    s_ack = 16'h0002;
    s_rdat[63:32] = 32'hCAFE_0001;
    @(negedge clk);
    s_ack = 16'h0;
    n_cmp++;
    if (ack !== 1'b1) begin
      n_err++;
      $display("FAIL abort_next: got ack=%b want 1", ack);
    end
    drop_req();
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] pat;
    logic [15:0] oh;
    bit          w;
    active = 16'h0007;
    for (int i = 0; i < 4; i++) begin
      pat = 32'h5A00_0000 + 32'(i) * 32'h0101_0011;
      w   = (i % 2) == 1;
      oh  = 16'h1 << i;
      drive_req(32'h3000_0000 | (32'(i) << 20) | 32'(i * 4), w, pat);
      if (i < 3) exp_q.push_back(w ? 32'h0 : pat);
      else       exp_q.push_back(32'hBAD0_0003);
      @(negedge clk);
      if (i < 3) begin
        n_cmp++;
        if (s_stb !== oh || s_we !== w) begin
          n_err++;
          $display("FAIL b2b_strobe[%0d]: got stb=%h we=%b want %h/%b",
                   i, s_stb, s_we, oh, w);
        end
        s_ack = oh;
        s_rdat[32*i +: 32] = pat;
        @(negedge clk);
        s_ack = 16'h0;
      end
      n_cmp++;
      if (ack !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ack[%0d]: got ack=%b want 1", i, ack);
      end
      drop_req();
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_reset;
    active = 16'h0020;
    drive_req(32'h3050_0000, 1'b0, 32'h0);
    @(negedge clk);
    s_ack = 16'h0010;
    @(negedge clk);
    s_ack = 16'h0;
    n_cmp++;
    if (ack !== 1'b0 || s_stb !== 16'h0020) begin
      n_err++;
      $display("FAIL foreign_ack: got ack=%b stb=%h want 0/0020", ack, s_stb);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ack, rdat, s_cyc, s_we, s_stb, s_sel, s_adr, s_dat, to} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got ack=%b dat=%h stb=%h cyc=%b to=%b, want all 0",
               ack, rdat, s_stb, s_cyc, to);
    end
    rst = 1'b0;
    drop_req();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_mapped();
    test_inactive();
    test_timeout();
    test_status();
    test_abort();
    test_back_to_back();
    test_ignore_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending responses want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_project_decoder.md
# wb_project_decoder

Wishbone address decoder and response mux between the Caravel management Wishbone port and the shared project slots in the user area. It gates each transaction by the per-project `active` select and forwards it to exactly one slot strobe. It returns that slot's registered ack and data, and answers unmapped, inactive or hung slots with an error word so the management core never stalls. It replaces direct wire-OR of slot `wbs_ack_o`/`wbs_dat_o`.

## Interface
Parameters:
- `NUM_SLOTS`, 16: project slots; slot index = `wbs_adr_i[23:20]`.
- `TIMEOUT`, 255: max cycles waiting for slot ack (1..255).
- `ERR_DATA`, 32'hBAD0_0000: error read word; low 4 bits replaced by the slot index.

Ports:
- `wb_clk_i`  in  1  clock; single clock domain.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  upstream Wishbone classic.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  registered ack to the master.
- `wbs_dat_o`  out  32  registered read data.
- `active`  in  NUM_SLOTS  per-slot enable (from `la_data_in`).
- `slot_cyc_o`, `slot_we_o`  out  1 each  shared downstream cycle and write enable.
- `slot_stb_o`  out  NUM_SLOTS  one-hot downstream strobe.
- `slot_sel_o`  out  4  latched byte selects.
- `slot_adr_o`, `slot_dat_o`  out  32 each  latched address and write data.
- `slot_ack_i`  in  NUM_SLOTS  per-slot ack.
- `slot_dat_i`  in  32*NUM_SLOTS  per-slot read data; slot n in bits [32n+31:32n].
- `timeout_o`  out  1  sticky: a timeout has occurred since reset.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, `wbs_cyc_i & wbs_stb_i` sampled: latch adr/dat/sel/we into `slot_*_o` and the slot index.
  - Go to BUSY when all of these hold: `adr[31:28]==4'h3`, slot < NUM_SLOTS, and `active[slot]`.
  - Otherwise go to RESP with error data.
- BUSY:
  - `slot_cyc_o=1` and `slot_stb_o[slot]=1`; all other strobe bits are 0.
  - Timeout counter increments each cycle.
  - `slot_ack_i[slot]`: capture `slot_dat_i` slice, go to RESP.
  - Acks from other slots are ignored.
  - Counter reaching TIMEOUT with no ack: load error data, set `timeout_o`, go to RESP.
  - Ack and timeout in the same cycle: the ack wins.
  - `wbs_cyc_i` drops: abort to IDLE, no `wbs_ack_o`, strobes cleared.
- RESP: `wbs_ack_o=1` for exactly one cycle with `wbs_dat_o` valid, then IDLE.
  - `wbs_dat_o` holds its value until the next RESP.
  - Writes return data 0 on success and error data on failure.
- Error data = `ERR_DATA | slot[3:0]`.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, counter 0, `timeout_o` 0.
- Reset asserted mid-transaction: at the next edge, strobes drop and no ack is issued.
- Request sampled at edge T:
  - `slot_stb_o` high in cycle T+1.
  - Error responses: `wbs_ack_o` high in cycle T+1.
- Slot ack sampled at edge A: `wbs_ack_o` high in cycle A+1.
  - Minimum mapped read latency is 2 cycles when the slot acks combinationally.
- Timeout: `wbs_ack_o` is issued TIMEOUT+1 cycles after `slot_stb_o` rises.
- After RESP, IDLE needs one cycle before accepting the next request. The master must drop `stb` after ack, per Wishbone classic.

## Configuration
- `WB_DECODER_STATUS_EN`
  - Defined: an address with `adr[27:24]==4'hF` decodes to an internal read-only status register, answered directly in RESP at T+1.
    - Register layout: {8'h0, timeout_count[7:0], last_timeout_slot[3:0], 11'h0, timeout_o}.
    - `timeout_count` saturates at 255.
    - Writes to the register are acked and ignored.
  - Undefined: that address range is treated as unmapped and returns error data. The status logic is not synthesized.

## Test plan
- Reset, then `active=16'h0001`, read 0x3000_0010 with slot 0 acking 3 cycles after `stb` and data 32'h1234_5678 -> `slot_stb_o=16'h0001`; `wbs_ack_o` the cycle after the slot ack; `wbs_dat_o=32'h1234_5678`.
- Read 0x3020_0000 with `active[2]=0` -> no slot strobe; ack at T+1; data 32'hBAD0_0002.
- Write 0x3030_0004 to active slot 3, which never acks -> ack 256 cycles after `stb`; data 32'hBAD0_0003; `timeout_o=1` and held.
- Slot 1 transaction, `wbs_cyc_i` dropped after 2 BUSY cycles -> strobes 0 next cycle; no `wbs_ack_o`; the next request is served normally.
- Slot 5 BUSY with `slot_ack_i[4]` pulsed -> ignored. Then `wb_rst_i` pulsed mid-BUSY -> all outputs 0 next cycle.
- With `WB_DECODER_STATUS_EN`, after one timeout on slot 3, read 0x3F00_0000 -> 32'h0001_3001. Without the macro, the same read -> 32'hBAD0_0000.
